// File: rtl/sha256_wgen.sv
// sha256_wgen: SHA-256 message schedule; loads 16 words, then streams W[0..ROUNDS-1]
// with its round index through a single registered output slot.
module sha256_wgen #(
   parameter int ROUNDS    = 64,
   parameter int CNT_WIDTH = 6
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [31:0]          in_word,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [31:0]          w_out,
   output logic [CNT_WIDTH-1:0] w_t,
   output logic                 w_valid,
   input  logic                 w_ready,
   output logic                 busy,
   output logic                 done
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_CALC  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;
   localparam logic [CNT_WIDTH-1:0] T_LAST  = CNT_WIDTH'(ROUNDS - 1);
   localparam logic [CNT_WIDTH-1:0] T_LOADED = CNT_WIDTH'(15);

   logic [1:0]           r_state;
   logic [CNT_WIDTH-1:0] r_t;
   logic [31:0]          r_m [16];
   logic [31:0]          r_w;
   logic [CNT_WIDTH-1:0] r_wt;
   logic                 r_valid;
   logic                 r_done;
   logic                 w_free;
   logic                 w_load;
   logic                 w_push;
   logic [31:0]          w_s0;
   logic [31:0]          w_s1;
   logic [31:0]          w_new;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // r_m[15] is W[t-1], so taps 14/9/1/0 are W[t-2], W[t-7], W[t-15], W[t-16]
   assign w_s0   = ror(r_m[1], 7) ^ ror(r_m[1], 18) ^ (r_m[1] >> 3);
   assign w_s1   = ror(r_m[14], 17) ^ ror(r_m[14], 19) ^ (r_m[14] >> 10);
   assign w_free = !r_valid || w_ready;
   assign w_load = (r_state == S_LOAD) && in_valid && w_free;
   assign w_push = w_load || ((r_state == S_CALC) && w_free);
   assign w_new  = w_load ? in_word : w_s1 + r_m[9] + w_s0 + r_m[0];

   assign in_ready = (r_state == S_LOAD) && w_free;
   assign busy     = (r_state == S_LOAD) || (r_state == S_CALC);
   assign w_out    = r_w;
   assign w_t      = r_wt;
   assign w_valid  = r_valid;
   assign done     = r_done;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_t     <= '0;
         r_w     <= '0;
         r_wt    <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < 16; i++) r_m[i] <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_push) begin
            r_w     <= w_new;
            r_wt    <= r_t;
            r_valid <= 1'b1;
            for (int i = 0; i < 15; i++) r_m[i] <= r_m[i+1];
            r_m[15] <= w_new;
            r_t     <= (r_t == T_LAST) ? r_t : r_t + 1'b1;
         end else if (w_ready) begin
            r_valid <= 1'b0;
         end
         if (r_state == S_IDLE && start) begin
            r_state <= S_LOAD;
            r_t     <= '0;
         end
         if (w_load && r_t == T_LOADED) r_state <= S_CALC;
         if (w_push && r_state == S_CALC && r_t == T_LAST) r_state <= S_DRAIN;
         if (r_state == S_DRAIN && r_valid && w_ready) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sha256_wgen.sv
// tb_sha256_wgen: directed vectors for sha256_wgen (64-round and 17-round instances)
// against an array-based schedule model and hand-computed words.
module tb_sha256_wgen;
   logic        CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0;
   logic        start2 = 1'b0;
   logic [31:0] in_word = '0;
   logic        in_valid = 1'b0;
   logic        w_ready = 1'b0;
   logic        in_ready1, in_ready2, w_valid1, w_valid2, busy1, busy2, done1, done2;
   logic [31:0] w_out1, w_out2;
   logic [5:0]  w_t1, w_t2;
   bit          sel = 1'b0;
   logic [31:0] wo;
   logic [5:0]  wt;
   logic        vo, ir, d, bsy;
   logic [31:0] blk   [16];
   logic [31:0] ref_w [64];
   logic [31:0] cap   [64];
   int          n_chk = 0;
   int          n_bad = 0;

   always #5 CLK = ~CLK;

   sha256_wgen #(.ROUNDS(64), .CNT_WIDTH(6)) dut1 (
      .CLK(CLK), .rst_n(rst_n), .start(start1), .in_word(in_word), .in_valid(in_valid),
      .in_ready(in_ready1), .w_out(w_out1), .w_t(w_t1), .w_valid(w_valid1),
      .w_ready(w_ready), .busy(busy1), .done(done1));

   sha256_wgen #(.ROUNDS(17), .CNT_WIDTH(6)) dut2 (
      .CLK(CLK), .rst_n(rst_n), .start(start2), .in_word(in_word), .in_valid(in_valid),
      .in_ready(in_ready2), .w_out(w_out2), .w_t(w_t2), .w_valid(w_valid2),
      .w_ready(w_ready), .busy(busy2), .done(done2));

   assign wo  = sel ? w_out2 : w_out1;
   assign wt  = sel ? w_t2 : w_t1;
   assign vo  = sel ? w_valid2 : w_valid1;
   assign ir  = sel ? in_ready2 : in_ready1;
   assign d   = sel ? done2 : done1;
   assign bsy = sel ? busy2 : busy1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      logic [63:0] xx;
      xx = {x, x} >> n;
      return xx[31:0];
   endfunction

   function automatic void model();
      for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
      for (int t = 16; t < 64; t++)
         ref_w[t] = (rr(ref_w[t-2], 17) ^ rr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10)) + ref_w[t-7]
                  + (rr(ref_w[t-15], 7) ^ rr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3)) + ref_w[t-16];
   endfunction

   function automatic void set_abc();
      for (int i = 0; i < 16; i++) blk[i] = '0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endfunction

   task automatic check_reset();
      check("rst_w_out", wo, 32'h0);
      check("rst_w_t", 32'(wt), 32'h0);
      check("rst_w_valid", 32'(vo), 32'h0);
      check("rst_done", 32'(d), 32'h0);
      check("rst_busy", 32'(bsy), 32'h0);
      check("rst_in_ready", 32'(ir), 32'h0);
   endtask

   // starts one block on the selected instance and consumes it; rst_at/start_at < 0 disable
   task automatic run(input bit s, input bit tog, input bit gaps, input int nexp,
                      input int rst_at, input int start_at);
      int fed, got, post, dones, budget;
      bit holding;
      logic [31:0] hold_w, hold_t;
      fed = 0; got = 0; post = 0; dones = 0; holding = 0; hold_w = '0; hold_t = '0;
      sel = s;
      model();
      w_ready = 1'b1;
      @(negedge CLK);
      if (s) start2 = 1'b1; else start1 = 1'b1;
      @(negedge CLK);
      start1 = 1'b0; start2 = 1'b0;
      for (budget = 0; budget < 2000; budget++) begin
         w_ready  = tog ? ~w_ready : 1'b1;
         in_valid = (fed < 16) && (!gaps || $urandom_range(0, 2) != 0);
         in_word  = in_valid ? blk[fed] : $urandom;
         start1   = (start_at >= 0) && (got == start_at);
         #1;
         if (holding) begin
            check("stall_w_out", wo, hold_w);
            check("stall_w_t", 32'(wt), hold_t);
            holding = 0;
         end
         if (vo && !w_ready) begin
            holding = 1; hold_w = wo; hold_t = 32'(wt);
         end
         if (start_at >= 0 && got == start_at) check("busy_at_start", 32'(bsy), 32'h1);
         if (rst_at >= 0 && vo && wt == 6'(rst_at)) begin
            rst_n = 1'b0;
            #1;
            check_reset();
            rst_n = 1'b1; in_valid = 1'b0; start1 = 1'b0;
            return;
         end
         if (in_valid && ir) fed++;
         if (vo && w_ready) begin
            check("w_t", 32'(wt), 32'(got));
            check("w_out", wo, ref_w[got]);
            cap[got] = wo;
            got++;
         end
         if (d) dones++;
         if (got == nexp) begin
            post++;
            if (post == 2) check("done_pulse", 32'(d), 32'h1);
            if (post == 3) begin
               check("done_count", 32'(dones), 32'h1);
               check("end_w_valid", 32'(vo), 32'h0);
               check("end_busy", 32'(bsy), 32'h0);
               break;
            end
         end
         @(negedge CLK);
      end
      check("block_finished", 32'(post), 32'h3);
      in_valid = 1'b0; start1 = 1'b0;
   endtask

   initial begin
      #1;
      check_reset();
      @(negedge CLK);
      @(negedge CLK);
      rst_n = 1'b1;
      @(negedge CLK);
      #1;
      check("idle_in_ready", 32'(ir), 32'h0);
      check("idle_busy", 32'(bsy), 32'h0);

      set_abc();
      run(0, 0, 0, 64, -1, -1);
      check("abc_w16", cap[16], 32'h61626380);
      check("abc_w17", cap[17], 32'h000F0000);
      check("abc_w18", cap[18], 32'h7DA86405);
      check("abc_w19", cap[19], 32'h600003C6);

      run(0, 1, 1, 64, -1, -1);
      run(0, 1, 0, 64, 30, -1);
      @(negedge CLK);
      run(0, 0, 0, 64, -1, -1);
      run(0, 0, 1, 64, -1, 40);

      for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
      run(0, 0, 0, 64, -1, -1);
      check("ones_w16", cap[16], 32'h203FFFFC);

      set_abc();
      run(1, 0, 0, 17, -1, -1);
      check("r17_w16", cap[16], 32'h61626380);
      run(1, 1, 1, 17, -1, -1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
